// File: rtl/mode_timeout_controller.sv
// mode_timeout_controller: per-mode countdown that strobes return_pulse when a timed mode expires
module mode_timeout_controller #(
  parameter int MODE_WIDTH = 3,
  parameter int CNT_WIDTH  = 16,
  parameter int TICK_DIV   = 100000000,
  parameter int WARN_TICKS = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [MODE_WIDTH-1:0]    current_mode,
  input  logic [2**MODE_WIDTH-1:0] timed_mask,
  input  logic [CNT_WIDTH-1:0]     timeout_load,
  input  logic                     extend,
  input  logic                     pause,
  output logic                     return_pulse,
  output logic                     warn,
  output logic                     active,
  output logic [CNT_WIDTH-1:0]     remaining
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  typedef enum logic [2:0] {IDLE, RUN, PAUSED, EXPIRED, HOLD} state_t;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [MODE_WIDTH-1:0] last_mode_q;
  logic pulse_q, pulse_d, warn_q, warn_d, active_q, active_d;
  logic mode_change, timed, arm, is_active, tick;
  always_comb begin
    mode_change = current_mode != last_mode_q;
    timed = timed_mask[current_mode];
    arm = timed && timeout_load != '0;
    is_active = state_q == RUN || state_q == PAUSED;
    // a tick already due completes even if pause rises in the same cycle
    tick = is_active && presc_q == PMAX && (state_q == RUN || !pause);
    state_d = state_q;
    rem_d = rem_q;
    presc_d = presc_q;
    pulse_d = 1'b0;
    if (state_q == IDLE || mode_change) begin
      state_d = arm ? RUN : timed ? HOLD : IDLE;
      rem_d = arm ? timeout_load : '0;
      presc_d = '0;
    end else if (is_active) begin
      if (extend) begin
        rem_d = timeout_load;
        presc_d = '0;
      end else if (tick) begin
        presc_d = '0;
        rem_d = rem_q == '0 ? '0 : rem_q - CNT_WIDTH'(1);
        pulse_d = rem_q == CNT_WIDTH'(1);
        state_d = pulse_d ? EXPIRED : pause ? PAUSED : RUN;
      end else if (pause) begin
        state_d = PAUSED;
      end else begin
        presc_d = presc_q + PW'(1);
        state_d = RUN;
      end
    end
    active_d = state_d == RUN || state_d == PAUSED;
    warn_d = active_d && rem_d <= CNT_WIDTH'(WARN_TICKS);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rem_q <= '0;
      presc_q <= '0;
      last_mode_q <= '0;
      pulse_q <= 1'b0;
      warn_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      presc_q <= presc_d;
      last_mode_q <= current_mode;
      pulse_q <= pulse_d;
      warn_q <= warn_d;
      active_q <= active_d;
    end
  end
  assign return_pulse = pulse_q;
  assign warn = warn_q;
  assign active = active_q;
  assign remaining = rem_q;
endmodule

// File: tb/tb_mode_timeout_controller.sv
// tb_mode_timeout_controller: directed checks of countdown, pause, extend, mode change and reset
module tb_mode_timeout_controller;
  logic clk = 1'b0;
  logic rstn;
  logic [2:0] current_mode;
  logic [7:0] timed_mask;
  logic [7:0] timeout_load;
  logic extend, pause;
  logic return_pulse, warn, active;
  logic [7:0] remaining;
  int vectors = 0;
  int errors = 0;
  int p, f;

  mode_timeout_controller #(.MODE_WIDTH(3), .CNT_WIDTH(8), .TICK_DIV(4), .WARN_TICKS(1)) dut (
    .clk(clk), .rstn(rstn), .current_mode(current_mode), .timed_mask(timed_mask),
    .timeout_load(timeout_load), .extend(extend), .pause(pause), .return_pulse(return_pulse),
    .warn(warn), .active(active), .remaining(remaining)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic watch(input int n, output int pulses, output int first);
    pulses = 0;
    first = 0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (return_pulse) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic idle_out();
    current_mode = 3'd0;
    step(1);
  endtask

  task automatic test_reset();
    rstn = 1'b0; current_mode = 3'd0; timed_mask = 8'b0000_1000;
    timeout_load = 8'd3; extend = 1'b0; pause = 1'b0;
    step(2);
    vectors++;
    if ({return_pulse, warn, active, remaining} !== 11'd0) begin
      errors++; $display("FAIL reset_outputs got=%b exp=0", {return_pulse, warn, active, remaining});
    end
    rstn = 1'b1;
    step(2);
    vectors++;
    if (active !== 1'b0) begin errors++; $display("FAIL idle_untimed active=%b exp=0", active); end
  endtask

  task automatic test_basic();
    current_mode = 3'd3;
    step(1);
    vectors++;
    if (active !== 1'b1 || remaining !== 8'd3 || warn !== 1'b0) begin
      errors++; $display("FAIL basic_entry act=%b rem=%0d warn=%b exp 1/3/0", active, remaining, warn);
    end
    step(4);
    vectors++;
    if (remaining !== 8'd2 || warn !== 1'b0) begin
      errors++; $display("FAIL basic_tick1 rem=%0d warn=%b exp 2/0", remaining, warn);
    end
    step(4);
    vectors++;
    if (remaining !== 8'd1 || warn !== 1'b1) begin
      errors++; $display("FAIL basic_tick2 rem=%0d warn=%b exp 1/1", remaining, warn);
    end
    step(3);
    vectors++;
    if (return_pulse !== 1'b0) begin errors++; $display("FAIL basic_early pulse=%b exp=0", return_pulse); end
    step(1);
    vectors++;
    if (return_pulse !== 1'b1 || remaining !== 8'd0 || active !== 1'b0 || warn !== 1'b0) begin
      errors++; $display("FAIL basic_expire p=%b rem=%0d act=%b warn=%b exp 1/0/0/0", return_pulse, remaining, active, warn);
    end
    watch(50, p, f);
    vectors++;
    if (p !== 0 || active !== 1'b0) begin errors++; $display("FAIL basic_no_repeat pulses=%0d act=%b exp 0/0", p, active); end
    idle_out();
  endtask

  task automatic test_pause();
    current_mode = 3'd3;
    step(5);
    pause = 1'b1;
    step(10);
    vectors++;
    if (remaining !== 8'd2 || warn !== 1'b0 || active !== 1'b1) begin
      errors++; $display("FAIL pause_frozen rem=%0d warn=%b act=%b exp 2/0/1", remaining, warn, active);
    end
    pause = 1'b0;
    watch(8, p, f);
    vectors++;
    if (p !== 1 || f !== 8) begin errors++; $display("FAIL pause_delay pulses=%0d at=%0d exp 1 at 8", p, f); end
    idle_out();
    current_mode = 3'd3;
    step(12);
    pause = 1'b1;
    step(1);
    vectors++;
    if (return_pulse !== 1'b1 || remaining !== 8'd0) begin
      errors++; $display("FAIL pause_final_tick p=%b rem=%0d exp 1/0", return_pulse, remaining);
    end
    pause = 1'b0;
    idle_out();
  endtask

  task automatic test_extend();
    current_mode = 3'd3;
    step(9);
    vectors++;
    if (remaining !== 8'd1 || warn !== 1'b1) begin errors++; $display("FAIL extend_pre rem=%0d warn=%b exp 1/1", remaining, warn); end
    extend = 1'b1;
    step(1);
    extend = 1'b0;
    vectors++;
    if (remaining !== 8'd3 || warn !== 1'b0) begin errors++; $display("FAIL extend_reload rem=%0d warn=%b exp 3/0", remaining, warn); end
    watch(12, p, f);
    vectors++;
    if (p !== 1 || f !== 12) begin errors++; $display("FAIL extend_delay pulses=%0d at=%0d exp 1 at 12", p, f); end
    idle_out();
    current_mode = 3'd3;
    step(12);
    extend = 1'b1;
    step(1);
    extend = 1'b0;
    vectors++;
    if (return_pulse !== 1'b0 || remaining !== 8'd3 || active !== 1'b1) begin
      errors++; $display("FAIL extend_final_tick p=%b rem=%0d act=%b exp 0/3/1", return_pulse, remaining, active);
    end
    idle_out();
  endtask

  task automatic test_mode_change();
    current_mode = 3'd3;
    step(6);
    current_mode = 3'd1;
    step(1);
    vectors++;
    if (active !== 1'b0 || return_pulse !== 1'b0) begin errors++; $display("FAIL mode_untimed act=%b p=%b exp 0/0", active, return_pulse); end
    watch(20, p, f);
    vectors++;
    if (p !== 0) begin errors++; $display("FAIL mode_untimed_quiet pulses=%0d exp 0", p); end
    current_mode = 3'd3;
    step(1);
    vectors++;
    if (active !== 1'b1 || remaining !== 8'd3) begin errors++; $display("FAIL mode_reload act=%b rem=%0d exp 1/3", active, remaining); end
    step(11);
    current_mode = 3'd1;
    step(1);
    vectors++;
    if (return_pulse !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL mode_final_tick p=%b act=%b exp 0/0", return_pulse, active); end
    watch(5, p, f);
    vectors++;
    if (p !== 0) begin errors++; $display("FAIL mode_final_quiet pulses=%0d exp 0", p); end
    idle_out();
  endtask

  task automatic test_zero_load();
    timeout_load = 8'd0;
    current_mode = 3'd3;
    step(1);
    timeout_load = 8'd3;
    watch(30, p, f);
    vectors++;
    if (p !== 0 || active !== 1'b0 || remaining !== 8'd0) begin
      errors++; $display("FAIL zero_hold pulses=%0d act=%b rem=%0d exp 0/0/0", p, active, remaining);
    end
    current_mode = 3'd2;
    watch(10, p, f);
    vectors++;
    if (p !== 0 || active !== 1'b0) begin errors++; $display("FAIL untimed_idle pulses=%0d act=%b exp 0/0", p, active); end
    idle_out();
  endtask

  task automatic test_reset_mid();
    current_mode = 3'd3;
    step(5);
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({return_pulse, warn, active, remaining} !== 11'd0) begin
      errors++; $display("FAIL reset_async got=%b exp=0", {return_pulse, warn, active, remaining});
    end
    step(3);
    rstn = 1'b1;
    step(1);
    vectors++;
    if (active !== 1'b1 || remaining !== 8'd3) begin errors++; $display("FAIL reset_rearm act=%b rem=%0d exp 1/3", active, remaining); end
    watch(12, p, f);
    vectors++;
    if (p !== 1 || f !== 12) begin errors++; $display("FAIL reset_rearm_expiry pulses=%0d at=%0d exp 1 at 12", p, f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_extend();
    test_mode_change();
    test_zero_load();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
